// File: rtl/wrr_arbiter_pkg.sv
// rtl/wrr_arbiter_pkg.sv - shared state encoding, default sizes and weight-slice helper for wrr_arbiter
package wrr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int DEFAULT_REQ_WIDTH    = 4;
  localparam int DEFAULT_WEIGHT_WIDTH = 4;

  // Weights arrive zero-extended to the largest supported packing (16 x 16 bits);
  // ww is the real per-requester width so the stride matches the caller's layout.
  function automatic logic [15:0] weight_slice(input logic [255:0] weights,
                                               input logic [3:0]   idx,
                                               input logic [4:0]   ww);
    logic [15:0] w;
    logic [7:0]  base;
    w    = '0;
    base = 8'(idx) * 8'(ww);
    for (int b = 0; b < 16; b++) begin
      if (5'(b) < ww) w[b] = weights[base + 8'(b)];
    end
    return w;
  endfunction

endpackage

// File: rtl/wrr_arbiter_rr_pick.sv
// rtl/wrr_arbiter_rr_pick.sv - rotating priority encoder: lowest set req at or above pointer, wrapping
module rr_pick #(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] pointer,
  output logic [N-1:0]   pick,
  output logic [IDW-1:0] pick_id,
  output logic           any
);

  logic [2*N-1:0] doubled;
  logic [N-1:0]   rotated;
  logic [IDW:0]   offset;
  logic [IDW:0]   sum;

  always_comb begin
    doubled = {req, req};
    rotated = N'(doubled >> pointer);
    offset  = '0;
    // Descending scan so the lowest set bit of the rotated view wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (rotated[i]) offset = (IDW+1)'(i);
    end
    sum = {1'b0, pointer} + offset;
    if (sum >= (IDW+1)'(N)) sum = sum - (IDW+1)'(N);
    any     = |req;
    pick_id = any ? sum[IDW-1:0] : '0;
    pick    = '0;
    if (any) pick[pick_id] = 1'b1;
  end

endmodule

// File: rtl/wrr_arbiter.sv
// rtl/wrr_arbiter.sv - weighted round-robin arbiter with beat-credit tenure and ready_in gating
module wrr_arbiter
  import wrr_arbiter_pkg::*;
#(
  parameter  int REQ_WIDTH    = DEFAULT_REQ_WIDTH,
  parameter  int WEIGHT_WIDTH = DEFAULT_WEIGHT_WIDTH,
  localparam int ID_WIDTH     = $clog2(REQ_WIDTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ready_in,
  input  logic [REQ_WIDTH-1:0]           req,
  input  logic [REQ_WIDTH*WEIGHT_WIDTH-1:0] weight,
  output logic [REQ_WIDTH-1:0]           grant,
  output logic [ID_WIDTH-1:0]            grant_id,
  output logic                           grant_valid,
  output logic                           beat
);

  state_t                  state, state_n;
  logic [REQ_WIDTH-1:0]    grant_n;
  logic [ID_WIDTH-1:0]     grant_id_n;
  logic [WEIGHT_WIDTH-1:0] credit, credit_n;
  logic [ID_WIDTH-1:0]     pointer, pointer_n;

  logic [ID_WIDTH-1:0]     next_owner;
  logic                    drop, last, release_now;
  logic [ID_WIDTH-1:0]     pick_ptr;
  logic [REQ_WIDTH-1:0]    pick_req;
  logic [REQ_WIDTH-1:0]    pick;
  logic [ID_WIDTH-1:0]     pick_id;
  logic                    pick_any;
  logic [WEIGHT_WIDTH-1:0] load_credit;
  logic [255:0]            weight_ext;

  assign weight_ext  = 256'(weight);
  assign grant_valid = |grant;

  rr_pick #(.N(REQ_WIDTH)) u_pick (
    .req     (pick_req),
    .pointer (pick_ptr),
    .pick    (pick),
    .pick_id (pick_id),
    .any     (pick_any)
  );

  always_comb begin
    next_owner  = (grant_id == ID_WIDTH'(REQ_WIDTH - 1)) ? '0 : grant_id + 1'b1;
    beat        = grant_valid & ready_in & req[grant_id];
    drop        = (state == GRANT) & ~req[grant_id];
    last        = beat & (credit == WEIGHT_WIDTH'(1));
    release_now = drop | last;
    // On release the pick already starts past the old owner, so no idle bubble.
    pick_ptr    = release_now ? next_owner : pointer;
    pick_req    = drop ? (req & ~grant) : req;
    load_credit = WEIGHT_WIDTH'(weight_slice(weight_ext, 4'(pick_id), 5'(WEIGHT_WIDTH)));
    if (load_credit == '0) load_credit = WEIGHT_WIDTH'(1);
  end

  always_comb begin
    state_n    = state;
    grant_n    = grant;
    grant_id_n = grant_id;
    credit_n   = credit;
    pointer_n  = pointer;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_n    = GRANT;
          grant_n    = pick;
          grant_id_n = pick_id;
          credit_n   = load_credit;
        end
      end
      GRANT: begin
        if (release_now) begin
          pointer_n = next_owner;
          if (pick_any) begin
            grant_n    = pick;
            grant_id_n = pick_id;
            credit_n   = load_credit;
          end else begin
            state_n    = IDLE;
            grant_n    = '0;
            grant_id_n = '0;
            credit_n   = '0;
          end
        end else if (beat) begin
          credit_n = credit - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      credit   <= '0;
      pointer  <= '0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      grant_id <= grant_id_n;
      credit   <= credit_n;
      pointer  <= pointer_n;
    end
  end

endmodule

// File: tb/tb_wrr_arbiter.sv
// tb/tb_wrr_arbiter.sv - self-checking bench for wrr_arbiter: vector table, directed corners, random vs reference model
module tb_wrr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready_in = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] weight = '0;
  logic [3:0]  grant;
  logic [1:0]  grant_id;
  logic        grant_valid;
  logic        beat;

  int tests = 0;
  int fails = 0;

  int   m_owner = -1;
  int   m_credit = 0;
  int   m_ptr = 0;
  logic last_beat;

  wrr_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .ready_in    (ready_in),
    .req         (req),
    .weight      (weight),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .beat        (beat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  r;
    logic [15:0] w;
    logic        rdy;
    logic        exp_beat;
    logic [3:0]  exp_grant;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_weight(input logic [15:0] w, input int i);
    int v;
    v = int'((w >> (4 * i)) & 16'hF);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int m_search(input logic [3:0] cand, input int from);
    for (int k = 0; k < 4; k++) begin
      if (cand[(from + k) % 4]) return (from + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_grant();
    return (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
  endfunction

  function automatic logic m_beat(input logic [3:0] r, input logic rdy);
    if (m_owner < 0) return 1'b0;
    return rdy & r[m_owner];
  endfunction

  task automatic model_edge(input logic [3:0] r, input logic [15:0] w, input logic rdy);
    int   f;
    logic b, drop;
    logic [3:0] cand;
    if (m_owner < 0) begin
      f = m_search(r, m_ptr);
      if (f >= 0) begin
        m_owner  = f;
        m_credit = m_weight(w, f);
      end
    end else begin
      b    = rdy & r[m_owner];
      drop = ~r[m_owner];
      if (drop || (b && m_credit == 1)) begin
        m_ptr = (m_owner + 1) % 4;
        cand  = r;
        if (drop) cand[m_owner] = 1'b0;
        f = m_search(cand, m_ptr);
        if (f >= 0) begin
          m_owner  = f;
          m_credit = m_weight(w, f);
        end else begin
          m_owner  = -1;
          m_credit = 0;
        end
      end else if (b) begin
        m_credit = m_credit - 1;
      end
    end
  endtask

  // Entered and left just after a falling edge.
  task automatic step(input logic [3:0] r, input logic [15:0] w, input logic rdy);
    req = r; weight = w; ready_in = rdy;
    #1;
    last_beat = beat;
    chk("beat", 32'(beat), 32'(m_beat(r, rdy)));
    @(posedge clk);
    model_edge(r, w, rdy);
    #1;
    chk("grant", 32'(grant), 32'(m_grant()));
    chk("grant_id", 32'(grant_id), 32'((m_owner < 0) ? 0 : m_owner));
    chk("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; ready_in = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_grant_valid", 32'(grant_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_owner = -1; m_credit = 0; m_ptr = 0;
  endtask

  vec_t tbl[8];

  initial begin
    logic [3:0]  rr;
    logic [15:0] ww;

    @(negedge clk);
    do_reset();

    // Weighted rotation w0=1 w1=2 w2=3: 0001 x1, 0010 x2, 0100 x3, back to 0001.
    tbl[0] = '{4'b0111, 16'h0321, 1'b1, 1'b0, 4'b0001};
    tbl[1] = '{4'b0111, 16'h0321, 1'b1, 1'b1, 4'b0010};
    tbl[2] = '{4'b0111, 16'h0321, 1'b1, 1'b1, 4'b0010};
    tbl[3] = '{4'b0111, 16'h0321, 1'b1, 1'b1, 4'b0100};
    tbl[4] = '{4'b0111, 16'h0321, 1'b1, 1'b1, 4'b0100};
    tbl[5] = '{4'b0111, 16'h0321, 1'b1, 1'b1, 4'b0100};
    tbl[6] = '{4'b0111, 16'h0321, 1'b1, 1'b1, 4'b0001};
    tbl[7] = '{4'b0111, 16'h0321, 1'b1, 1'b1, 4'b0010};
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].r, tbl[i].w, tbl[i].rdy);
      chk("tbl_beat", 32'(last_beat), 32'(tbl[i].exp_beat));
      chk("tbl_grant", 32'(grant), 32'(tbl[i].exp_grant));
    end

    // Reset asserted during owner 0's second beat clears grant at once.
    do_reset();
    step(4'b1111, 16'h2222, 1'b1);
    step(4'b1111, 16'h2222, 1'b1);
    chk("mid_pre_grant", 32'(grant), 32'b0001);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_valid", 32'(grant_valid), 32'd0);
    @(negedge clk);
    do_reset();
    step(4'b1111, 16'h2222, 1'b1);
    chk("after_rst_owner0", 32'(grant), 32'b0001);

    // Backpressure: owner 1 weight 3, stall 4 cycles after the first beat.
    do_reset();
    step(4'b0011, 16'h0031, 1'b1);
    step(4'b0011, 16'h0031, 1'b1);
    chk("bp_owner1", 32'(grant), 32'b0010);
    step(4'b0011, 16'h0031, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(4'b0011, 16'h0031, 1'b0);
      chk("bp_stall_beat", 32'(last_beat), 32'd0);
      chk("bp_stall_grant", 32'(grant), 32'b0010);
    end
    step(4'b0011, 16'h0031, 1'b1);
    chk("bp_hold", 32'(grant), 32'b0010);
    step(4'b0011, 16'h0031, 1'b1);
    chk("bp_release", 32'(grant), 32'b0001);

    // Early release by de-assertion; pointer then sits past owner 0.
    do_reset();
    step(4'b0011, 16'h0014, 1'b1);
    step(4'b0011, 16'h0014, 1'b1);
    step(4'b0010, 16'h0014, 1'b1);
    chk("early_nobeat", 32'(last_beat), 32'd0);
    chk("early_grant", 32'(grant), 32'b0010);
    step(4'b0011, 16'h0014, 1'b1);
    chk("early_next", 32'(grant), 32'b0001);

    // Sole requester with zero weight is re-granted every beat.
    do_reset();
    step(4'b1000, 16'h0000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(4'b1000, 16'h0000, 1'b1);
      chk("sole_beat", 32'(last_beat), 32'd1);
      chk("sole_grant", 32'(grant), 32'b1000);
    end

    // Wrap-around: pointer reaches 3, req=1001 gives owner 3 then owner 0.
    do_reset();
    step(4'b0100, 16'h1111, 1'b1);
    step(4'b1001, 16'h1111, 1'b1);
    chk("wrap_owner3", 32'(grant), 32'b1000);
    step(4'b1001, 16'h1111, 1'b1);
    chk("wrap_owner0", 32'(grant), 32'b0001);

    // Random traffic checked against the reference model.
    do_reset();
    rr = 4'($urandom);
    ww = 16'($urandom);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) rr = 4'($urandom);
      if ($urandom_range(0, 15) == 0) ww = 16'($urandom);
      step(rr, ww, ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wrr_arbiter.md
Name: wrr_arbiter

Overview:
- Weighted round-robin arbiter that shares one downstream resource between REQ_WIDTH requesters.
- Each grant is held for up to a per-requester number of accepted beats, then rotates.
- Sits in front of the shared datapath. Exposes a registered one-hot grant plus an encoded owner ID.
- Transfers are gated by the downstream ready_in handshake.

Parameters:
- REQ_WIDTH, 4, number of requesters (2..16).
- WEIGHT_WIDTH, 4, width of each per-requester beat weight.
- ID_WIDTH, $clog2(REQ_WIDTH), width of grant_id (derived, not overridden).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- ready_in  input  1  downstream accepts a beat this cycle.
- req  input  REQ_WIDTH  per-requester request, level-sensitive.
- weight  input  REQ_WIDTH*WEIGHT_WIDTH  packed weights; requester i uses bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH].
- grant  output  REQ_WIDTH  registered one-hot grant, 0 when idle.
- grant_id  output  ID_WIDTH  index of current owner, 0 when idle.
- grant_valid  output  1  high iff grant is non-zero.
- beat  output  1  combinational: grant_valid & ready_in & req[grant_id]; marks an accepted beat.

Behaviour:
- Reset (async, rst=1), all outputs and state cleared immediately:
  - grant=0, grant_id=0, grant_valid=0
  - state=IDLE, credit=0, pointer=0 (requester 0 has highest priority first)
- Pick function: lowest-index set req bit at or above pointer, wrapping modulo REQ_WIDTH. This is a rotating priority encoder.
- States: IDLE, GRANT.
- IDLE:
  - If any req bit is set, then at the next edge: owner=pick, grant set, state=GRANT, and credit loaded with weight[owner].
  - A weight of 0 is treated as 1.
  - Latency: req to grant is 1 cycle.
- GRANT:
  - Each beat decrements credit by 1.
  - ready_in low: grant and credit are held, with no timeout.
  - The weight input is sampled only at grant load; later changes do not affect the current tenure.
- Release occurs on either of:
  - (a) a beat while credit==1 (last beat), or
  - (b) req[owner]==0, regardless of credit.
- On release:
  - pointer=(owner+1) mod REQ_WIDTH, computed combinationally for the same-cycle pick.
  - If any req is set, excluding req[owner] when the release is by de-assertion, the next owner is granted at the same edge. No idle bubble.
  - Otherwise go to IDLE with grant=0.
- Sole requester that exhausts its credit and still requests:
  - The pointer wraps back to it and it is re-granted at the next edge with fresh credit.
  - grant stays continuously high, and credit reloads.
- Simultaneous release and new requests: the new req values are visible to the same-cycle pick.
- req de-asserting exactly on a would-be beat: no beat is counted (beat requires req[owner]), and the owner is released by rule (b).
- Grant never changes while a beat is pending, except on rule (a) or (b).
- Invariants: grant is always one-hot or zero; grant_id is consistent with grant.
- credit width is WEIGHT_WIDTH. It never underflows: it is reloaded or cleared on release.

Decomposition:
- Shared package/include holds:
  - the state encodings (IDLE=1'b0, GRANT=1'b1)
  - the default REQ_WIDTH/WEIGHT_WIDTH
  - the weight-slice helper function
- One sub-module, rr_pick: combinational rotating priority encoder.
  - Inputs: req, pointer.
  - Outputs: one-hot pick, pick_id, any.
  - It is reusable by the plain round-robin arbiter.

Test Plan:
- Reset mid-grant:
  - Stimulus: req=4'b1111, weights all 2, ready_in=1; assert rst during the second beat of owner 0.
  - Required: grant=0 immediately. After release, owner 0 is granted first again.
- Weighted rotation:
  - Stimulus: req=4'b0111, weights {w0=1,w1=2,w2=3}, ready_in=1.
  - Required: grant sequence 0001 ×1, 0010 ×2, 0100 ×3, repeating with no bubble cycles.
- Backpressure:
  - Stimulus: owner 1, weight 3; ready_in low for 4 cycles after the first beat.
  - Required: grant held at 0010, beat=0 during the stall, and release after 2 more beats.
- Early release:
  - Stimulus: req=4'b0011, w0=4; drop req[0] after 1 beat.
  - Required: grant becomes 0010 at the next edge, and pointer moves past 0.
- Sole requester and zero weight:
  - Stimulus: req=4'b1000, weight3=0.
  - Required: grant stays 1000, credit reloads every beat, and it is treated as 1.
- Wrap-around:
  - Stimulus: pointer at 3, req=4'b1001.
  - Required: owner 3 is granted, then owner 0.
